// File: rtl/mem_arbiter_pkg.sv
// Shared FSM encoding and channel identifiers for the memory arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] CH_INST = 2'd0;
  localparam logic [1:0] CH_DRD  = 2'd1;
  localparam logic [1:0] CH_DWR  = 2'd2;
endpackage

// File: rtl/mem_arbiter_slot.sv
// One-entry request holder: loads on request capture, empties when the bus transaction completes.
module mem_arbiter_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_addr,
  input  logic [3:0]  load_wstrb,
  input  logic [31:0] load_wdata,
  output logic        valid,
  output logic [31:0] addr,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
      wstrb <= '0;
      wdata <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      wstrb <= load_wstrb;
      wdata <= load_wdata;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Merges instruction-read, data-read and data-write channels onto one single-outstanding bus.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit INST_FIRST = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_INST_RDEN,
  input  logic [31:0] MEM_INST_RIADDR,
  output logic [31:0] MEM_INST_ROADDR,
  output logic        MEM_INST_RVALID,
  output logic [31:0] MEM_INST_RDATA,
  input  logic        MEM_DATA_RDEN,
  input  logic [31:0] MEM_DATA_RIADDR,
  output logic [31:0] MEM_DATA_ROADDR,
  output logic        MEM_DATA_RVALID,
  output logic [31:0] MEM_DATA_RDATA,
  input  logic        MEM_DATA_WREN,
  input  logic [3:0]  MEM_DATA_WSTRB,
  input  logic [31:0] MEM_DATA_WADDR,
  input  logic [31:0] MEM_DATA_WDATA,
  output logic        MEM_WAIT,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_WSTRB,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_ACK,
  input  logic        BUS_RVALID,
  input  logic [31:0] BUS_RDATA
);
  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic        inst_v, drd_v, dwr_v;
  logic [31:0] inst_addr, drd_addr, dwr_addr;
  logic [3:0]  inst_wstrb, drd_wstrb, dwr_wstrb;
  logic [31:0] inst_wdata, drd_wdata, dwr_wdata;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        capture, sel_we, done_wr, done_rd;

  // Busy flag comes only from registered state so upstream sees no input-to-output path.
  assign MEM_WAIT = inst_v | drd_v | dwr_v | (state_q != IDLE);
  assign capture  = ~MEM_WAIT;
  assign sel_we   = (sel_q == CH_DWR);
  assign done_wr  = (state_q == ISSUE) && BUS_ACK && sel_we;
  assign done_rd  = (state_q == RD_WAIT) && BUS_RVALID;

  mem_arbiter_slot u_inst (
    .clk(CLK), .rst_n(RST), .load(capture & MEM_INST_RDEN),
    .clear(done_rd && sel_q == CH_INST),
    .load_addr(MEM_INST_RIADDR), .load_wstrb(4'd0), .load_wdata(32'd0),
    .valid(inst_v), .addr(inst_addr), .wstrb(inst_wstrb), .wdata(inst_wdata)
  );

  mem_arbiter_slot u_drd (
    .clk(CLK), .rst_n(RST), .load(capture & MEM_DATA_RDEN),
    .clear(done_rd && sel_q == CH_DRD),
    .load_addr(MEM_DATA_RIADDR), .load_wstrb(4'd0), .load_wdata(32'd0),
    .valid(drd_v), .addr(drd_addr), .wstrb(drd_wstrb), .wdata(drd_wdata)
  );

  mem_arbiter_slot u_dwr (
    .clk(CLK), .rst_n(RST), .load(capture & MEM_DATA_WREN),
    .clear(done_wr),
    .load_addr(MEM_DATA_WADDR), .load_wstrb(MEM_DATA_WSTRB), .load_wdata(MEM_DATA_WDATA),
    .valid(dwr_v), .addr(dwr_addr), .wstrb(dwr_wstrb), .wdata(dwr_wdata)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wstrb = '0;
    sel_wdata = '0;
    case (sel_q)
      CH_INST: begin sel_addr = inst_addr; sel_wstrb = inst_wstrb; sel_wdata = inst_wdata; end
      CH_DRD:  begin sel_addr = drd_addr;  sel_wstrb = drd_wstrb;  sel_wdata = drd_wdata;  end
      CH_DWR:  begin sel_addr = dwr_addr;  sel_wstrb = dwr_wstrb;  sel_wdata = dwr_wdata;  end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      sel_q   <= CH_INST;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    BUS_REQ   = 1'b0;
    BUS_WE    = 1'b0;
    BUS_ADDR  = '0;
    BUS_WSTRB = '0;
    BUS_WDATA = '0;
    case (state_q)
      IDLE: begin
        if (dwr_v || drd_v || inst_v) state_d = ISSUE;
        // Write always wins so a same-cycle read observes the written data.
        if (dwr_v)                    sel_d = CH_DWR;
        else if (INST_FIRST && inst_v) sel_d = CH_INST;
        else if (drd_v)               sel_d = CH_DRD;
        else if (inst_v)              sel_d = CH_INST;
      end
      ISSUE: begin
        BUS_REQ  = 1'b1;
        BUS_WE   = sel_we;
        BUS_ADDR = sel_addr;
        if (sel_we) begin
          BUS_WSTRB = sel_wstrb;
          BUS_WDATA = sel_wdata;
        end
        if (BUS_ACK) state_d = sel_we ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        if (BUS_RVALID) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      MEM_INST_RVALID <= 1'b0;
      MEM_INST_RDATA  <= '0;
      MEM_INST_ROADDR <= '0;
      MEM_DATA_RVALID <= 1'b0;
      MEM_DATA_RDATA  <= '0;
      MEM_DATA_ROADDR <= '0;
    end else begin
      MEM_INST_RVALID <= 1'b0;
      MEM_DATA_RVALID <= 1'b0;
      if (done_rd && sel_q == CH_INST) begin
        MEM_INST_RVALID <= 1'b1;
        MEM_INST_RDATA  <= BUS_RDATA;
        MEM_INST_ROADDR <= sel_addr;
      end
      if (done_rd && sel_q == CH_DRD) begin
        MEM_DATA_RVALID <= 1'b1;
        MEM_DATA_RDATA  <= BUS_RDATA;
        MEM_DATA_ROADDR <= sel_addr;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected bus and response items are queued, a monitor checks responses.
module tb_mem_arbiter;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } bus_t;

  typedef struct {
    logic        ch;
    logic [31:0] addr;
    logic [31:0] data;
    logic        wt;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_rden = 1'b0, data_rden = 1'b0, data_wren = 1'b0;
  logic [31:0] inst_riaddr = '0, data_riaddr = '0, data_waddr = '0, data_wdata = '0;
  logic [3:0]  data_wstrb = '0;
  logic        bus_ack = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  logic [31:0] inst_roaddr, inst_rdata, data_roaddr, data_rdata, bus_addr, bus_wdata;
  logic        inst_rvalid, data_rvalid, mem_wait, bus_req, bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] f_inst_roaddr, f_inst_rdata, f_data_roaddr, f_data_rdata, f_bus_addr, f_bus_wdata;
  logic        f_inst_rvalid, f_data_rvalid, f_mem_wait, f_bus_req, f_bus_we;
  logic [3:0]  f_bus_wstrb;

  bus_t        bus_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] f_log[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.INST_FIRST(1'b0)) dut (
    .CLK(clk), .RST(rst),
    .MEM_INST_RDEN(inst_rden), .MEM_INST_RIADDR(inst_riaddr), .MEM_INST_ROADDR(inst_roaddr),
    .MEM_INST_RVALID(inst_rvalid), .MEM_INST_RDATA(inst_rdata),
    .MEM_DATA_RDEN(data_rden), .MEM_DATA_RIADDR(data_riaddr), .MEM_DATA_ROADDR(data_roaddr),
    .MEM_DATA_RVALID(data_rvalid), .MEM_DATA_RDATA(data_rdata),
    .MEM_DATA_WREN(data_wren), .MEM_DATA_WSTRB(data_wstrb), .MEM_DATA_WADDR(data_waddr),
    .MEM_DATA_WDATA(data_wdata), .MEM_WAIT(mem_wait),
    .BUS_REQ(bus_req), .BUS_WE(bus_we), .BUS_ADDR(bus_addr), .BUS_WSTRB(bus_wstrb),
    .BUS_WDATA(bus_wdata), .BUS_ACK(bus_ack), .BUS_RVALID(bus_rvalid), .BUS_RDATA(bus_rdata)
  );

  // Second instance shares all stimulus; its timing matches, only the read order differs.
  mem_arbiter #(.INST_FIRST(1'b1)) dut_if (
    .CLK(clk), .RST(rst),
    .MEM_INST_RDEN(inst_rden), .MEM_INST_RIADDR(inst_riaddr), .MEM_INST_ROADDR(f_inst_roaddr),
    .MEM_INST_RVALID(f_inst_rvalid), .MEM_INST_RDATA(f_inst_rdata),
    .MEM_DATA_RDEN(data_rden), .MEM_DATA_RIADDR(data_riaddr), .MEM_DATA_ROADDR(f_data_roaddr),
    .MEM_DATA_RVALID(f_data_rvalid), .MEM_DATA_RDATA(f_data_rdata),
    .MEM_DATA_WREN(data_wren), .MEM_DATA_WSTRB(data_wstrb), .MEM_DATA_WADDR(data_waddr),
    .MEM_DATA_WDATA(data_wdata), .MEM_WAIT(f_mem_wait),
    .BUS_REQ(f_bus_req), .BUS_WE(f_bus_we), .BUS_ADDR(f_bus_addr), .BUS_WSTRB(f_bus_wstrb),
    .BUS_WDATA(f_bus_wdata), .BUS_ACK(bus_ack), .BUS_RVALID(bus_rvalid), .BUS_RDATA(bus_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    fails++;
    $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bus_t e;
    e.we = we; e.addr = a; e.strb = s; e.data = d;
    bus_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic ch, input logic [31:0] a, input logic [31:0] d, input logic wt);
    rsp_t e;
    e.ch = ch; e.addr = a; e.data = d; e.wt = wt;
    rsp_q.push_back(e);
  endtask

  task automatic issue(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                       input logic wr, input logic [31:0] wa, input logic [3:0] ws, input logic [31:0] wd);
    @(negedge clk);
    inst_rden = ir; inst_riaddr = ia;
    data_rden = dr; data_riaddr = da;
    data_wren = wr; data_waddr = wa; data_wstrb = ws; data_wdata = wd;
    @(negedge clk);
    inst_rden = 1'b0; data_rden = 1'b0; data_wren = 1'b0;
  endtask

  // Acts as the memory: waits for a request, checks it, acks, optionally returns read data.
  task automatic serve(input int ack_dly, input int rv_dly, input logic [31:0] rdata);
    bus_t        e;
    logic [31:0] a0;
    int          n;
    n = 0;
    @(negedge clk);
    while (!bus_req && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus_req) begin
      bad("bus_req_timeout", 32'd0, 32'd1);
      return;
    end
    if (bus_q.size() == 0) begin
      bad("bus_unexpected", bus_addr, 32'd0);
      return;
    end
    e = bus_q.pop_front();
    chk("bus_we", {31'd0, bus_we}, {31'd0, e.we});
    chk("bus_addr", bus_addr, e.addr);
    chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, e.strb});
    chk("bus_wdata", bus_wdata, e.data);
    a0 = bus_addr;
    repeat (ack_dly) begin
      @(negedge clk);
      chk("req_hold", {31'd0, bus_req}, 32'd1);
      chk("addr_hold", bus_addr, a0);
      chk("wait_busy", {31'd0, mem_wait}, 32'd1);
    end
    f_log.push_back(f_bus_addr);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    if (rv_dly > 0) begin
      repeat (rv_dly - 1) @(negedge clk);
      bus_rvalid = 1'b1;
      bus_rdata  = rdata;
      @(negedge clk);
      bus_rvalid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (inst_rvalid || data_rvalid) begin
      chk("one_strobe", {31'd0, inst_rvalid & data_rvalid}, 32'd0);
      if (rsp_q.size() == 0) begin
        bad("rsp_unexpected", {31'd0, data_rvalid}, 32'd0);
      end else begin
        e = rsp_q.pop_front();
        chk("rsp_channel", {31'd0, data_rvalid}, {31'd0, e.ch});
        chk("rsp_addr", e.ch ? data_roaddr : inst_roaddr, e.addr);
        chk("rsp_data", e.ch ? data_rdata : inst_rdata, e.data);
        chk("rsp_wait", {31'd0, mem_wait}, {31'd0, e.wt});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_mem_wait", {31'd0, mem_wait}, 32'd0);
    chk("rst_rvalid", {30'd0, inst_rvalid, data_rvalid}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_roaddr", inst_roaddr | data_roaddr, 32'd0);
    chk("rst_rdata", inst_rdata | data_rdata, 32'd0);
    rst = 1'b1;

    // Single instruction read
    exp_bus(1'b0, 32'h100, 4'h0, 32'h0);
    exp_rsp(1'b0, 32'h100, 32'hDEAD_BEEF, 1'b0);
    issue(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("wait_after_capture", {31'd0, mem_wait}, 32'd1);
    serve(0, 2, 32'hDEAD_BEEF);

    // Write, data read and instruction read captured together
    exp_bus(1'b1, 32'h200, 4'hF, 32'h1234_5678);
    exp_bus(1'b0, 32'h200, 4'h0, 32'h0);
    exp_bus(1'b0, 32'h000, 4'h0, 32'h0);
    exp_rsp(1'b1, 32'h200, 32'h1234_5678, 1'b1);
    exp_rsp(1'b0, 32'h000, 32'h0BAD_F00D, 1'b0);
    issue(1'b1, 32'h0, 1'b1, 32'h200, 1'b1, 32'h200, 4'hF, 32'h1234_5678);
    serve(0, 0, 32'h0);
    chk("wait_after_write", {31'd0, mem_wait}, 32'd1);
    serve(1, 2, 32'h1234_5678);
    chk("inst_roaddr_hold", inst_roaddr, 32'h100);
    chk("inst_rdata_hold", inst_rdata, 32'hDEAD_BEEF);
    serve(0, 3, 32'h0BAD_F00D);

    // Stalled ACK; a request presented while busy must be dropped
    exp_bus(1'b0, 32'h600, 4'h0, 32'h0);
    exp_rsp(1'b1, 32'h600, 32'h6666_0000, 1'b0);
    issue(1'b0, 32'h0, 1'b1, 32'h600, 1'b0, 32'h0, 4'h0, 32'h0);
    fork
      serve(5, 1, 32'h6666_0000);
      begin
        repeat (2) @(negedge clk);
        data_rden = 1'b1; data_riaddr = 32'h999;
        repeat (3) @(negedge clk);
        data_rden = 1'b0;
      end
    join
    repeat (8) begin
      @(negedge clk);
      chk("no_extra_txn", {31'd0, bus_req}, 32'd0);
    end
    chk("idle_after_stall", {31'd0, mem_wait}, 32'd0);

    // Read ordering for both priority settings
    f_log.delete();
    exp_bus(1'b0, 32'h80, 4'h0, 32'h0);
    exp_bus(1'b0, 32'h40, 4'h0, 32'h0);
    exp_rsp(1'b1, 32'h80, 32'h1111_0080, 1'b1);
    exp_rsp(1'b0, 32'h40, 32'h2222_0040, 1'b0);
    issue(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 4'h0, 32'h0);
    serve(0, 2, 32'h1111_0080);
    serve(0, 2, 32'h2222_0040);
    if (f_log.size() == 2) begin
      chk("if_first_addr", f_log[0], 32'h40);
      chk("if_second_addr", f_log[1], 32'h80);
    end else begin
      bad("if_log_size", f_log.size(), 32'd2);
    end
    chk("if_inst_roaddr", f_inst_roaddr, 32'h40);
    chk("if_inst_rdata", f_inst_rdata, 32'h1111_0080);
    chk("if_data_roaddr", f_data_roaddr, 32'h80);
    chk("if_data_rdata", f_data_rdata, 32'h2222_0040);

    // Reset while waiting for read data, then a stray response
    exp_bus(1'b0, 32'h500, 4'h0, 32'h0);
    issue(1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    serve(0, 0, 32'h0);
    chk("rdwait_busy", {31'd0, mem_wait}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_async_wait", {31'd0, mem_wait}, 32'd0);
    chk("rst_async_req", {31'd0, bus_req}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_0BAD;
    @(negedge clk);
    bus_rvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stray_wait", {31'd0, mem_wait}, 32'd0);
      chk("stray_req", {31'd0, bus_req}, 32'd0);
      chk("stray_rvalid", {30'd0, inst_rvalid, data_rvalid}, 32'd0);
    end

    // Write-only request with partial strobes
    exp_bus(1'b1, 32'h300, 4'h3, 32'hCAFE_0001);
    issue(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h300, 4'h3, 32'hCAFE_0001);
    serve(0, 0, 32'h0);
    chk("wr_wait_drop", {31'd0, mem_wait}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("wr_no_rvalid", {30'd0, inst_rvalid, data_rvalid}, 32'd0);
    end

    n = 0;
    while (rsp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_queue_empty", rsp_q.size(), 32'd0);
    chk("bus_queue_empty", bus_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sits directly downstream of the MMU on the physical-address side. It merges the instruction-read channel and the data read/write channels into one single-outstanding system memory bus. Each request is captured into a one-entry per-channel slot, served in priority order, and the read response is returned on the originating channel. It generates the MEM_WAIT hazard consumed by the MMU.

Parameters:
INST_FIRST  0  1 = instruction read outranks data read; data write always highest

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-low reset
MEM_INST_RDEN  in  1  instruction read request, sampled only when MEM_WAIT=0
MEM_INST_RIADDR  in  32  instruction read address
MEM_INST_ROADDR  out  32  address of returned instruction word
MEM_INST_RVALID  out  1  one-cycle instruction response strobe
MEM_INST_RDATA  out  32  instruction word
MEM_DATA_RDEN  in  1  data read request, sampled only when MEM_WAIT=0
MEM_DATA_RIADDR  in  32  data read address
MEM_DATA_ROADDR  out  32  address of returned data word
MEM_DATA_RVALID  out  1  one-cycle data response strobe
MEM_DATA_RDATA  out  32  data word
MEM_DATA_WREN  in  1  data write request, sampled only when MEM_WAIT=0
MEM_DATA_WSTRB  in  4  byte enables
MEM_DATA_WADDR  in  32  write address
MEM_DATA_WDATA  in  32  write data
MEM_WAIT  out  1  busy; upstream must not rely on new requests being captured
BUS_REQ  out  1  bus request; held until BUS_ACK
BUS_WE  out  1  1 = write, 0 = read
BUS_ADDR  out  32  bus address, passed unmodified
BUS_WSTRB  out  4  byte enables (0 on reads)
BUS_WDATA  out  32  write data (0 on reads)
BUS_ACK  in  1  bus accepts request this cycle
BUS_RVALID  in  1  read data valid
BUS_RDATA  in  32  read data

Behaviour:
- Reset (RST=0, async): all slots empty, FSM=IDLE. BUS_REQ, BUS_WE, MEM_*_RVALID and MEM_WAIT are 0. All address/data/strobe outputs are 0.
- Capture: on a rising edge with MEM_WAIT=0, each asserted request (INST_RDEN, DATA_RDEN, DATA_WREN) loads its own slot. Up to 3 slots load in the same cycle.
- Requests are ignored while MEM_WAIT=1. Upstream re-presents them after MEM_WAIT falls.
- MEM_WAIT = any slot valid OR FSM != IDLE. It is derived from registers only, with no combinational path from inputs.
- FSM states:
  - IDLE: if any slot is valid, latch the highest-priority slot into sel and go to ISSUE.
  - ISSUE: BUS_REQ=1. BUS_WE, BUS_ADDR, BUS_WSTRB and BUS_WDATA are driven from the sel slot and stay stable until BUS_ACK.
    - On BUS_ACK with a write: clear the slot and go to IDLE.
    - On BUS_ACK with a read: go to RD_WAIT.
  - RD_WAIT: BUS_REQ=0. On BUS_RVALID, register RDATA plus the sel slot address into the sel channel's response outputs, clear the slot, and go to IDLE.
- Priority order: write, then data read, then instruction read. With INST_FIRST=1 the order is write, instruction read, data read.
- Write before a same-cycle read guarantees read-after-write ordering.
- Latency:
  - Capture at edge T. BUS_REQ is high in cycle T+2, i.e. IDLE then ISSUE.
  - If BUS_RVALID arrives in cycle R, RVALID is high for exactly one cycle at R+1.
  - MEM_WAIT falls in that same cycle when no other slot is pending.
- Only one response strobe is asserted per cycle. An inactive channel's RVALID is 0, and its RDATA/ROADDR hold their last values.
- BUS_RVALID in IDLE or ISSUE is ignored. This covers stray or late responses, including those after reset.
- Reset mid-transaction drops BUS_REQ immediately and discards all slots.

Decomposition:
- Package mem_arbiter_pkg holds:
  - FSM state encoding (IDLE, ISSUE, RD_WAIT).
  - Channel ID constants CH_INST, CH_DRD, CH_DWR.
- Sub-module mem_arbiter_slot: one-entry holder with valid, addr, wstrb and wdata; load and clear inputs. Instantiated 3 times. Its wstrb and wdata fields are unused for the read channels.

Test Plan:
- Inst read 0x0000_0100, BUS_ACK in the first ISSUE cycle, BUS_RVALID 2 cycles later with 0xDEAD_BEEF -> INST_RVALID for one cycle, ROADDR=0x100, RDATA=0xDEADBEEF. MEM_WAIT=0 on that cycle.
- Same-cycle WREN (0x200, STRB=0xF, 0x1234_5678), DATA_RDEN (0x200) and INST_RDEN (0x0) -> bus order is write, data read, inst read (INST_FIRST=0). Data response addr=0x200. MEM_WAIT stays high until the inst RVALID.
- BUS_ACK withheld for 5 cycles -> BUS_REQ and BUS_ADDR stay stable throughout. A new DATA_RDEN during MEM_WAIT=1 is not captured and produces no extra bus transaction.
- INST_FIRST=1 with simultaneous inst read 0x40 and data read 0x80 -> BUS_ADDR=0x40 first, then 0x80.
- RST low while in RD_WAIT, then BUS_RVALID=1 after release -> no RVALID output, MEM_WAIT=0, BUS_REQ=0.
- Write-only request 0x300 with STRB=0x3 -> BUS_WE=1, BUS_WSTRB=0x3. No RVALID on either channel. MEM_WAIT drops the cycle after BUS_ACK.
